shift_tx_ctrl: RTL and testbench

//  Sequencer for a W-bit parallel-in/serial-out shift path.
//  - Accepts words on a valid/ready input port.
//  - Loads each word into the internal shift register and shifts it out LSB-first.
//  - Advances one bit per tick, so the serial rate is set externally by a tick

---
 rtl/shift_tx_pkg.sv | 15 +
 rtl/piso_shift.sv | 36 +++
 rtl/shift_tx_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_tx_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/shift_tx_pkg.sv
// Shared types and helpers for the serial transmit sequencer.
// Build option: SHIFT_TX_CTRL_PARITY_EN adds a trailing even-parity bit.
package shift_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in/serial-out shift register, LSB first, zero fill from the MSB.
// nxt_o is the bit 0 value the register will hold after this edge.
module piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic         sh_i,
  input  logic [W-1:0] d_i,
  output logic         nxt_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = d_i;
    end else if (sh_i) begin
      q_d = {1'b0, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign nxt_o = q_d[0];

endmodule

// File: rtl/shift_tx_ctrl.sv
// Word-to-serial sequencer: valid/ready word input, one bit per tick out.
// Build option: SHIFT_TX_CTRL_PARITY_EN appends an even-parity bit (PAR state).
module shift_tx_ctrl
  import shift_tx_pkg::*;
#(
  parameter int   W          = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_first,
  output logic         busy
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          out_q;
  logic          vld_q;
  logic          fst_q;
  logic          at_last;
  logic          xfer;
  logic          shift_en;
  logic          nxt_bit;

`ifdef SHIFT_TX_CTRL_PARITY_EN
  logic par_q;
  assign in_ready = (state_q == IDLE) | ((state_q == PAR) & tick);
`else
  assign in_ready = (state_q == IDLE) | (at_last & tick);
`endif

  assign at_last  = (state_q == SHIFT) & (cnt_q == LAST);
  assign xfer     = in_valid & in_ready;
  assign shift_en = (state_q == SHIFT) & tick & (cnt_q != LAST);

  piso_shift #(.W(W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .ld_i  (xfer),
    .sh_i  (shift_en),
    .d_i   (in_data),
    .nxt_o (nxt_bit)
  );

  // A transfer always wins: it covers both idle start and zero-gap reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
      vld_q   <= 1'b0;
      fst_q   <= 1'b0;
`ifdef SHIFT_TX_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (xfer) begin
      state_q <= SHIFT;
      cnt_q   <= '0;
      out_q   <= nxt_bit;
      vld_q   <= 1'b1;
      fst_q   <= 1'b1;
`ifdef SHIFT_TX_CTRL_PARITY_EN
      par_q   <= ^in_data;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          if (tick) begin
            fst_q <= 1'b0;
            if (cnt_q != LAST) begin
              cnt_q <= cnt_q + 1'b1;
              out_q <= nxt_bit;
            end else begin
`ifdef SHIFT_TX_CTRL_PARITY_EN
              state_q <= PAR;
              out_q   <= par_q;
`else
              state_q <= IDLE;
              out_q   <= IDLE_LEVEL;
              vld_q   <= 1'b0;
`endif
            end
          end
        end
`ifdef SHIFT_TX_CTRL_PARITY_EN
        PAR: begin
          if (tick) begin
            state_q <= IDLE;
            out_q   <= IDLE_LEVEL;
            vld_q   <= 1'b0;
            fst_q   <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          out_q   <= IDLE_LEVEL;
          vld_q   <= 1'b0;
          fst_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = out_q;
  assign ser_valid = vld_q;
  assign ser_first = fst_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl (W=4, idle level 0).
// Observed bundle per cycle: {ser_out, ser_valid, ser_first, in_ready, busy}.
module tb_shift_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_first;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  shift_tx_ctrl #(.W(4), .IDLE_LEVEL(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [4:0] obs;
    rst = 1'b1; tick = 1'b1; in_valid = 1'b0; in_data = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      obs = {ser_out, ser_valid, ser_first, in_ready, busy};
      n_chk++;
      if (obs !== 5'b00010)
        $display("FAIL reset cyc%0d obs=%b exp=%b", k, obs, 5'b00010);
      else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] e [0:5];
    logic [4:0] obs;
    e = '{5'b00010, 5'b11101, 5'b11001, 5'b01001, 5'b11011, 5'b00010};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = (k == 0); in_data = 4'b1011; tick = 1'b1; rst = 1'b0;
      #1;
      obs = {ser_out, ser_valid, ser_first, in_ready, busy};
      n_chk++;
      if (obs !== e[k])
        $display("FAIL single cyc%0d obs=%b exp=%b", k, obs, e[k]);
      else n_pass++;
    end
  endtask

  task automatic test_slow_tick();
    logic [3:0] w;
    logic [4:0] ex;
    logic [4:0] obs;
    int b;
    w = 4'b0110;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      tick = (k % 3 == 0);
      in_valid = (k == 0) || (k >= 5 && k <= 8);
      in_data = (k == 0) ? w : 4'hF;
      #1;
      if (k == 0 || k == 13) begin
        ex = 5'b00010;
      end else begin
        b = (k - 1) / 3;
        ex = {w[b], 1'b1, (b == 0), (k == 12), 1'b1};
      end
      obs = {ser_out, ser_valid, ser_first, in_ready, busy};
      n_chk++;
      if (obs !== ex)
        $display("FAIL slow_tick cyc%0d obs=%b exp=%b", k, obs, ex);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e [0:9];
    logic [4:0] obs;
    e = '{5'b00010, 5'b01101, 5'b11001, 5'b01001, 5'b11011,
          5'b11101, 5'b01001, 5'b11001, 5'b01011, 5'b00010};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tick = 1'b1;
      in_valid = (k <= 4);
      in_data = (k == 0) ? 4'hA : 4'h5;
      #1;
      obs = {ser_out, ser_valid, ser_first, in_ready, busy};
      n_chk++;
      if (obs !== e[k])
        $display("FAIL back_to_back cyc%0d obs=%b exp=%b", k, obs, e[k]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [4:0] e [0:8];
    logic [4:0] obs;
    e = '{5'b00010, 5'b11101, 5'b11001, 5'b00010, 5'b11101,
          5'b11001, 5'b01001, 5'b01011, 5'b00010};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rst = (k == 2);
      tick = (k != 3);
      in_valid = (k == 0) || (k == 3);
      in_data = (k == 0) ? 4'hF : 4'h3;
      #1;
      obs = {ser_out, ser_valid, ser_first, in_ready, busy};
      n_chk++;
      if (obs !== e[k])
        $display("FAIL abort cyc%0d obs=%b exp=%b", k, obs, e[k]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_parity();
    logic [4:0] e [0:12];
    logic [4:0] obs;
    e = '{5'b00010, 5'b11101, 5'b11001, 5'b01001, 5'b11001,
          5'b11011, 5'b00010, 5'b11101, 5'b11001, 5'b01001,
          5'b01001, 5'b01011, 5'b00010};
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      tick = 1'b1;
      in_valid = (k == 0) || (k == 6);
      in_data = (k == 0) ? 4'b1011 : 4'b0011;
      #1;
      obs = {ser_out, ser_valid, ser_first, in_ready, busy};
      n_chk++;
      if (obs !== e[k])
        $display("FAIL parity cyc%0d obs=%b exp=%b", k, obs, e[k]);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    test_reset();
`ifdef SHIFT_TX_CTRL_PARITY_EN
    test_parity();
`else
    test_single();
    test_slow_tick();
    test_back_to_back();
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
